// File: rtl/doc_uart_loader.sv
// doc_uart_loader: 8N1 UART receiver that writes printable text into the
// document RAM in reading order, sharing the write port via doc_we/doc_gnt.
module doc_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned COLS         = 20,
    parameter int unsigned ROWS         = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    input  logic       clear,
    output logic [8:0] doc_a,
    output logic [7:0] doc_d,
    output logic       doc_we,
    input  logic       doc_gnt,
    output logic       busy,
    output logic       full,
    output logic       overrun,
    output logic       frame_err,
    output logic [8:0] char_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0] COL_LAST   = 5'(COLS - 1);
    localparam logic [3:0] ROW_LAST   = 4'(ROWS - 1);
    localparam logic [7:0] CH_LF      = 8'h0A;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    rx_state_t      state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           rx_m;
    logic           rx_s;
    logic           rx_done;
    logic           hold_v;
    logic [7:0]     hold_b;
    logic [3:0]     row;
    logic [4:0]     col;

    // Bytes that may enter the holding register: printable ASCII or line feed.
    function automatic logic accept_byte(input logic [7:0] b);
        return (b == CH_LF) || ((b >= 8'h20) && (b <= 8'h7E));
    endfunction

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receiver FSM: start-bit qualification, mid-bit sampling, stop-bit check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARM;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_ARM: begin
                    cnt <= '0;
                    if (rx_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            frame_err <= !clear;
                            state     <= ST_ARM;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    // Holding register, cursor and document write handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v     <= 1'b0;
            hold_b     <= '0;
            row        <= '0;
            col        <= '0;
            doc_we     <= 1'b0;
            doc_a      <= '0;
            doc_d      <= '0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            char_count <= '0;
        end else if (clear) begin
            hold_v     <= 1'b0;
            row        <= '0;
            col        <= '0;
            doc_we     <= 1'b0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            char_count <= '0;
        end else begin
            if (doc_we && doc_gnt) begin
                doc_we <= 1'b0;
                hold_v <= 1'b0;
                if (char_count != 9'h1FF) char_count <= char_count + 9'd1;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) full <= 1'b1;
                    else                 row  <= row + 4'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end else if (hold_v && (hold_b == CH_LF)) begin
                hold_v <= 1'b0;
                col    <= '0;
                if (row == ROW_LAST) full <= 1'b1;
                else                 row  <= row + 4'd1;
            end else if (hold_v && !doc_we) begin
                doc_we <= 1'b1;
                doc_a  <= {row, col};
                doc_d  <= hold_b;
            end

            // A freshly received byte is only kept if the holding register is free.
            if (rx_done && enable && !full && accept_byte(shreg)) begin
                if (hold_v) begin
                    overrun <= 1'b1;
                end else begin
                    hold_v <= 1'b1;
                    hold_b <= shreg;
                end
            end
        end
    end

    // Busy flag: frame in progress or a character still waiting to be written.
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= (state != ST_IDLE) || hold_v;
    end

endmodule

// File: doc/doc_uart_loader.md
Name: doc_uart_loader

Overview:
- UART receive-side feeder for the document RAM (9-bit address = {row[3:0], col[4:0]}, 8-bit data).
- Receives 8N1 serial text on an RsRx pin and writes printable characters into the document in reading order, so the VGA text layer displays them and the messenger can send them back.
- Sits upstream of the document write port and shares that port with the text editor through a request/grant handshake.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud)
COLS, 20, visible columns per row (col 0..COLS-1)
ROWS, 15, visible rows (row 0..ROWS-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx  in  1  UART serial input, asynchronous, idle high
enable  in  1  1 = accept received characters; 0 = receive and discard
clear  in  1  one-cycle pulse: cursor to row 0/col 0; clears full, overrun and frame_err
doc_a  out  9  document write address {row, col}
doc_d  out  8  document write data (ASCII)
doc_we  out  1  write request; held with doc_a/doc_d until granted
doc_gnt  in  1  write grant; a write commits on the cycle doc_we & doc_gnt
busy  out  1  receiver not in IDLE, or holding register full
full  out  1  sticky: cursor past row ROWS-1; all further characters dropped
overrun  out  1  sticky: byte arrived while holding register occupied
frame_err  out  1  one-cycle pulse on a bad stop bit
char_count  out  9  characters committed since reset/clear; saturates at 511

Behaviour:
- rx passes through a 2-FF synchronizer (rx_s). All sampling uses rx_s, so there are 2 cycles of input latency.
- Reset values: doc_we=0, doc_a=0, doc_d=0, busy=0, full=0, overrun=0, frame_err=0, char_count=0. Reset also sets cursor row=0/col=0, FSM=ARM, holding register empty, and baud counter=0.
- Receiver FSM:
  - ARM: wait for rx_s=1 for one sample, then go to IDLE. This prevents a held-low line from retriggering.
  - IDLE: rx_s=0 -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2-1, resample. rx_s=0 -> DATA. rx_s=1 -> IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1: byte done -> IDLE.
    - rx_s=0: frame_err pulses 1 cycle, byte discarded -> ARM.
- Byte classification happens on byte done:
  - 0x0D and any byte <0x20 other than 0x0A: ignored.
  - Bytes >=0x7F: ignored.
  - enable=0 or full=1: ignored.
  - Otherwise (0x20..0x7E or 0x0A): loaded into the holding register. If the holding register is still occupied, the new byte is dropped and overrun is set.
- Writer (independent of the receiver):
  - Holding register occupied and byte printable: drive doc_we=1, doc_a={row,col}, doc_d=byte. Hold until doc_gnt.
  - Commit cycle: holding register emptied, char_count++ (saturating), col++.
  - If col was COLS-1: col=0, row++.
  - If row was ROWS-1 at wrap: full=1.
  - Byte 0x0A: no write, no doc_we. Next cycle: col=0, row++; full=1 if row was ROWS-1.
  - doc_we deasserts the cycle after commit. Back-to-back writes need at least 1 idle cycle.
- clear: takes priority over a same-cycle commit. The pending write is abandoned, doc_we=0, holding register emptied. The receiver FSM is not affected.
- rst during a frame: everything returns to reset values; the rest of that frame is ignored via ARM/IDLE.
- Address bits col 20..31 are never generated.

Test Plan:
- CLKS_PER_BIT=16, doc_gnt tied 1, send 0x41 'A' -> one doc_we pulse with doc_a=0x000, doc_d=0x41; char_count=1; busy falls 0 after stop bit.
- Send 21 bytes 'a' -> writes at addresses 0x000..0x013, then 0x020 (row 1, col 0); char_count=21.
- Send "X", 0x0D, 0x0A, "Y" -> 'X' at 0x000, 'Y' at 0x020; only 2 doc_we commits.
- doc_gnt held 0 for 400 cycles while two bytes arrive -> first byte held stable on doc_a/doc_d; second byte dropped, overrun=1; commit occurs when doc_gnt rises.
- Frame with stop bit 0 -> frame_err 1-cycle pulse, no doc_we; next valid frame (after line idle) writes normally.
- Fill 300 printable bytes -> last commit at 0x1D3 (row 14, col 19), full=1, char_count=300; byte 301 produces no write; clear pulse -> full=0, next byte writes at 0x000.
